// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - oversampling 8N1 receiver with a small output FIFO for simulation harnesses
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rxs_q, rxs_d;
    logic          rxs_prev_q, rxs_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          push;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic          fifo_empty, fifo_full, pop, push_ok;

    // Receiver FSM: start detection, mid-bit sampling, stop-bit check
    always_comb begin
        rx_meta_d   = rx;
        rxs_d       = rx_meta_q;
        rxs_prev_d  = rxs_q;
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q && rxs_prev_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A line that is high again at mid start bit was a glitch
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // Hold here through a break so it reports only one framing error
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output FIFO: a push into a full FIFO survives only if the head is popped in the same cycle
    always_comb begin
        fifo_empty = (wr_q == rd_q);
        fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop        = !fifo_empty && out_ready;
        push_ok    = push && (!fifo_full || pop);
        overrun_d  = push && fifo_full && !pop;
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = shift_q;
            wr_d                = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    // State registers; reset overrides any pending push or pop
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            mem_q       <= '{default: '0};
            wr_q        <= '0;
            rd_q        <= '0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            rxs_prev_q  <= rxs_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = mem_q[rd_q[AW-1:0]];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb/tb_uart_rx_monitor.sv - table-driven and scoreboarded bench for uart_rx_monitor
module tb_uart_rx_monitor;
    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_monitor #(.CLKS_PER_BIT(N), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop_low;
        int         stop_len;
        int         gap;
        logic       exp_push;
        int         exp_fe;
    } vec_t;

    vec_t       vecs [8];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got_mem [256];
    int         got_wr = 0;
    int         got_rd = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         fe_base, ov_base, exp_fe_total, lat;
    logic       s_a, s_b, s_c, s_d, s_e;
    logic [7:0] d_a;

    // Record every handshake and flag pulse the DUT produces
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_mem[got_wr % 256] <= out_data;
                got_wr <= got_wr + 1;
            end
            if (frame_err) fe_cnt <= fe_cnt + 1;
            if (overrun) ov_cnt <= ov_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int nbits, input logic stop_low, input int stop_len);
        rx = 1'b0;
        repeat (N) tick();
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            repeat (N) tick();
        end
        if (nbits == 8) begin
            rx = ~stop_low;
            repeat (stop_len) tick();
        end
        rx = 1'b1;
    endtask

    task automatic sb_compare(input string name);
        check({name, "_count"}, got_wr - got_rd, exp_q.size());
        while (got_rd < got_wr && exp_q.size() > 0) begin
            check({name, "_data"}, {24'd0, got_mem[got_rd % 256]}, {24'd0, exp_q.pop_front()});
            got_rd++;
        end
        got_rd = got_wr;
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{8'h00, 1'b0, N,  0,  1'b1, 0};
        vecs[1] = '{8'hFF, 1'b0, N,  0,  1'b1, 0};
        vecs[2] = '{8'hA5, 1'b0, N,  20, 1'b1, 0};
        vecs[3] = '{8'h3C, 1'b1, 40, 20, 1'b0, 1};
        vecs[4] = '{8'h80, 1'b0, N,  5,  1'b1, 0};
        vecs[5] = '{8'h7F, 1'b0, N,  0,  1'b1, 0};
        vecs[6] = '{8'h01, 1'b0, N,  10, 1'b1, 0};
        vecs[7] = '{8'hC3, 1'b0, 24, 10, 1'b1, 0};

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (5) tick();

        // Single byte: latency from rx falling edge and busy drop after stop sample
        lat = -1;
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 8, 1'b0, N);
            begin
                for (int k = 1; k <= 200; k++) begin
                    tick();
                    if (k == 154) s_a = busy;
                    if (k == 155) begin s_b = busy; d_a = out_data; end
                    if (out_valid && lat < 0) lat = k;
                end
            end
        join
        check("single_latency", lat, 155);
        check("single_busy_at_stop", s_a, 1);
        check("single_busy_after", s_b, 0);
        check("single_data", d_a, 8'h55);
        out_ready = 1'b1;
        repeat (3) tick();
        sb_compare("single");
        check("single_drained", out_valid, 0);

        // Vector table, consumer always ready, including back-to-back frames
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        exp_fe_total = 0;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
            exp_fe_total += vecs[i].exp_fe;
            send_frame(vecs[i].data, 8, vecs[i].stop_low, vecs[i].stop_len);
            if (vecs[i].gap > 0) begin
                repeat (vecs[i].gap) tick();
                check($sformatf("vec%0d_frame_err", i), fe_cnt - fe_base, exp_fe_total);
            end
        end
        repeat (20) tick();
        sb_compare("table");
        check("table_overrun", ov_cnt - ov_base, 0);
        check("table_busy", busy, 0);

        // Framing error: stop bit held low for 40 cycles
        fe_base = fe_cnt;
        fork
            send_frame(8'h3C, 8, 1'b1, 40);
            begin
                for (int k = 1; k <= 200; k++) begin
                    tick();
                    if (k == 154) s_a = frame_err;
                    if (k == 155) s_b = frame_err;
                    if (k == 156) s_c = frame_err;
                    if (k == 186) s_d = busy;
                    if (k == 187) s_e = busy;
                end
            end
        join
        check("ferr_before", s_a, 0);
        check("ferr_pulse", s_b, 1);
        check("ferr_after", s_c, 0);
        check("ferr_busy_wait", s_d, 1);
        check("ferr_busy_idle", s_e, 0);
        check("ferr_count", fe_cnt - fe_base, 1);
        sb_compare("ferr");

        // Glitch: rx low for 3 cycles only
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        fork
            begin rx = 1'b0; repeat (3) tick(); rx = 1'b1; end
            begin
                for (int k = 1; k <= 30; k++) begin
                    tick();
                    if (k == 3) s_a = busy;
                    if (k == 10) s_b = busy;
                    if (k == 11) s_c = busy;
                end
            end
        join
        repeat (150) tick();
        check("glitch_start", s_a, 1);
        check("glitch_mid", s_b, 1);
        check("glitch_idle", s_c, 0);
        check("glitch_ferr", fe_cnt - fe_base, 0);
        check("glitch_overrun", ov_cnt - ov_base, 0);
        sb_compare("glitch");

        // Overrun: five bytes into a 4-deep FIFO with no consumer
        out_ready = 1'b0;
        ov_base = ov_cnt;
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) exp_q.push_back(8'(b));
            send_frame(8'(b), 8, 1'b0, N);
        end
        repeat (10) tick();
        check("overrun_count", ov_cnt - ov_base, 1);
        check("overrun_head", out_data, 8'h01);
        out_ready = 1'b1;
        repeat (8) tick();
        sb_compare("overrun");

        // Full FIFO with a pop in the same cycle as the fifth push
        out_ready = 1'b0;
        ov_base = ov_cnt;
        for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 8, 1'b0, N);
        repeat (4) tick();
        fork
            send_frame(8'h05, 8, 1'b0, N);
            begin repeat (154) tick(); out_ready = 1'b1; tick(); out_ready = 1'b0; end
        join
        repeat (10) tick();
        check("fullpop_overrun", ov_cnt - ov_base, 0);
        check("fullpop_head", out_data, 8'h02);
        out_ready = 1'b1;
        repeat (8) tick();
        sb_compare("fullpop");

        // Reset mid-frame, with a stale byte sitting in the FIFO
        out_ready = 1'b0;
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        send_frame(8'h99, 8, 1'b0, N);
        repeat (4) tick();
        check("stale_valid", out_valid, 1);
        fork
            send_frame(8'h7E, 7, 1'b0, 0);
            begin
                repeat (88) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                s_a = busy;
                s_b = out_valid;
            end
        join
        repeat (200) tick();
        check("midrst_busy", s_a, 0);
        check("midrst_fifo_cleared", s_b, 0);
        check("midrst_no_push", out_valid, 0);
        check("midrst_ferr", fe_cnt - fe_base, 0);
        check("midrst_overrun", ov_cnt - ov_base, 0);
        out_ready = 1'b1;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 8, 1'b0, N);
        repeat (20) tick();
        sb_compare("after_rst");
        check("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
